// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, branch-flush squash,
// memory-stall hold and a saturating count of inserted bubbles.
module id_ex_hazard_reg #(
    parameter int DATA_W  = 16,
    parameter int REG_W   = 4,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_stall,
    input  logic               flush,
    input  logic               ID_Valid,
    input  logic [REG_W-1:0]   ID_Rs,
    input  logic [REG_W-1:0]   ID_Rt,
    input  logic [REG_W-1:0]   ID_Rd,
    input  logic               ID_UsesRs,
    input  logic               ID_UsesRt,
    input  logic               ID_RegWrite,
    input  logic               ID_MemRead,
    input  logic               ID_MemWrite,
    input  logic               ID_MemToReg,
    input  logic               ID_ALUSrc,
    input  logic [ALUOP_W-1:0] ID_ALUOp,
    input  logic [DATA_W-1:0]  ID_RsData,
    input  logic [DATA_W-1:0]  ID_RtData,
    input  logic [DATA_W-1:0]  ID_Imm,
    input  logic [DATA_W-1:0]  ID_PC,
    output logic               IDEX_Valid,
    output logic [REG_W-1:0]   IDEX_Rs,
    output logic [REG_W-1:0]   IDEX_Rt,
    output logic [REG_W-1:0]   IDEX_Rd,
    output logic               IDEX_UsesRs,
    output logic               IDEX_UsesRt,
    output logic               IDEX_RegWrite,
    output logic               IDEX_MemRead,
    output logic               IDEX_MemWrite,
    output logic               IDEX_MemToReg,
    output logic               IDEX_ALUSrc,
    output logic [ALUOP_W-1:0] IDEX_ALUOp,
    output logic [DATA_W-1:0]  IDEX_RsData,
    output logic [DATA_W-1:0]  IDEX_RtData,
    output logic [DATA_W-1:0]  IDEX_Imm,
    output logic [DATA_W-1:0]  IDEX_PC,
    output logic               hazard_stall,
    output logic               pc_write,
    output logic               ifid_write,
    output logic [CNT_W-1:0]   bubble_cnt
);

    logic rs_match;
    logic rt_match;
    logic store_data_only;
    logic load_use;
    logic bubble;

    logic               valid_next;
    logic [REG_W-1:0]   rs_next;
    logic [REG_W-1:0]   rt_next;
    logic [REG_W-1:0]   rd_next;
    logic               uses_rs_next;
    logic               uses_rt_next;
    logic               reg_write_next;
    logic               mem_read_next;
    logic               mem_write_next;
    logic               mem_to_reg_next;
    logic               alu_src_next;
    logic [ALUOP_W-1:0] alu_op_next;
    logic [DATA_W-1:0]  rs_data_next;
    logic [DATA_W-1:0]  rt_data_next;
    logic [DATA_W-1:0]  imm_next;
    logic [DATA_W-1:0]  pc_next;
    logic [CNT_W-1:0]   cnt_next;

    // A store whose only dependence is its data operand is served by MEM-to-MEM forwarding.
    always_comb begin
        rs_match        = ID_UsesRs && (ID_Rs == IDEX_Rd);
        rt_match        = ID_UsesRt && (ID_Rt == IDEX_Rd);
        store_data_only = ID_MemWrite && !rs_match;
        load_use        = IDEX_Valid && IDEX_MemRead && (IDEX_Rd != '0) &&
                          (rs_match || (rt_match && !store_data_only));
    end

    assign hazard_stall = ID_Valid & load_use & ~flush & ~mem_stall;
    assign pc_write     = ~(hazard_stall | mem_stall);
    assign ifid_write   = pc_write;
    assign bubble       = flush | hazard_stall;

    always_comb begin
        valid_next      = IDEX_Valid;
        rs_next         = IDEX_Rs;
        rt_next         = IDEX_Rt;
        rd_next         = IDEX_Rd;
        uses_rs_next    = IDEX_UsesRs;
        uses_rt_next    = IDEX_UsesRt;
        reg_write_next  = IDEX_RegWrite;
        mem_read_next   = IDEX_MemRead;
        mem_write_next  = IDEX_MemWrite;
        mem_to_reg_next = IDEX_MemToReg;
        alu_src_next    = IDEX_ALUSrc;
        alu_op_next     = IDEX_ALUOp;
        rs_data_next    = IDEX_RsData;
        rt_data_next    = IDEX_RtData;
        imm_next        = IDEX_Imm;
        pc_next         = IDEX_PC;
        if (!mem_stall) begin
            if (bubble) begin
                valid_next      = 1'b0;
                rs_next         = '0;
                rt_next         = '0;
                rd_next         = '0;
                uses_rs_next    = 1'b0;
                uses_rt_next    = 1'b0;
                reg_write_next  = 1'b0;
                mem_read_next   = 1'b0;
                mem_write_next  = 1'b0;
                mem_to_reg_next = 1'b0;
                alu_src_next    = 1'b0;
                alu_op_next     = '0;
                rs_data_next    = '0;
                rt_data_next    = '0;
                imm_next        = '0;
                pc_next         = '0;
            end else begin
                valid_next      = ID_Valid;
                rs_next         = ID_Rs;
                rt_next         = ID_Rt;
                rd_next         = ID_Rd;
                uses_rs_next    = ID_UsesRs;
                uses_rt_next    = ID_UsesRt;
                reg_write_next  = ID_RegWrite;
                mem_read_next   = ID_MemRead;
                mem_write_next  = ID_MemWrite;
                mem_to_reg_next = ID_MemToReg;
                alu_src_next    = ID_ALUSrc;
                alu_op_next     = ID_ALUOp;
                rs_data_next    = ID_RsData;
                rt_data_next    = ID_RtData;
                imm_next        = ID_Imm;
                pc_next         = ID_PC;
            end
        end
    end

    // Only hazard bubbles are counted; flush bubbles and held cycles are not.
    always_comb begin
        cnt_next = bubble_cnt;
        if (hazard_stall && (bubble_cnt != '1)) begin
            cnt_next = bubble_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            IDEX_Valid    <= 1'b0;
            IDEX_Rs       <= '0;
            IDEX_Rt       <= '0;
            IDEX_Rd       <= '0;
            IDEX_UsesRs   <= 1'b0;
            IDEX_UsesRt   <= 1'b0;
            IDEX_RegWrite <= 1'b0;
            IDEX_MemRead  <= 1'b0;
            IDEX_MemWrite <= 1'b0;
            IDEX_MemToReg <= 1'b0;
            IDEX_ALUSrc   <= 1'b0;
            IDEX_ALUOp    <= '0;
            IDEX_RsData   <= '0;
            IDEX_RtData   <= '0;
            IDEX_Imm      <= '0;
            IDEX_PC       <= '0;
            bubble_cnt    <= '0;
        end else begin
            IDEX_Valid    <= valid_next;
            IDEX_Rs       <= rs_next;
            IDEX_Rt       <= rt_next;
            IDEX_Rd       <= rd_next;
            IDEX_UsesRs   <= uses_rs_next;
            IDEX_UsesRt   <= uses_rt_next;
            IDEX_RegWrite <= reg_write_next;
            IDEX_MemRead  <= mem_read_next;
            IDEX_MemWrite <= mem_write_next;
            IDEX_MemToReg <= mem_to_reg_next;
            IDEX_ALUSrc   <= alu_src_next;
            IDEX_ALUOp    <= alu_op_next;
            IDEX_RsData   <= rs_data_next;
            IDEX_RtData   <= rt_data_next;
            IDEX_Imm      <= imm_next;
            IDEX_PC       <= pc_next;
            bubble_cnt    <= cnt_next;
        end
    end

endmodule
